// File: rtl/mem_bridge.sv
// Bridges the CPU's fetch and data ports onto one shared req/ack memory, serving data before fetch.
// Optional wait-timeout watchdog compiled in with MEM_BRIDGE_TIMEOUT_EN.
module mem_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] instructionAddress,
    input  logic [ADDR_WIDTH-1:0] dataMemAddress,
    input  logic [DATA_WIDTH-1:0] dataOut,
    input  logic                  toMemWriteEnable,
    input  logic                  dataMemRead,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic [DATA_WIDTH-1:0] dataIn,
    output logic                  stall,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_req,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  err
);

    typedef enum logic [1:0] {IDLE, D_ACC, I_ACC, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] daddr_q, daddr_d;
    logic [ADDR_WIDTH-1:0] iaddr_q, iaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  err_q, err_d;
    logic                  in_access;
    logic                  acc_timeout;
    logic                  acc_done;
    logic [DATA_WIDTH-1:0] fill_dat;

    assign in_access = (state_q == D_ACC) || (state_q == I_ACC);

`ifdef MEM_BRIDGE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_q, wait_d;

    // Expiry lands on the edge where the count would reach TIMEOUT_CYCLES.
    assign acc_timeout = in_access && !mem_ack && (wait_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wait_d = '0;
        if (in_access && (state_d == state_q)) begin
            wait_d = wait_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign acc_timeout = 1'b0;
`endif

    assign acc_done = mem_ack || acc_timeout;
    assign fill_dat = acc_timeout ? {DATA_WIDTH{1'b1}} : mem_rdata;

    always_comb begin
        state_d = state_q;
        daddr_d = daddr_q;
        iaddr_d = iaddr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        instr_d = instr_q;
        din_d   = din_q;
        err_d   = err_q || acc_timeout;
        case (state_q)
            IDLE: begin
                iaddr_d = instructionAddress;
                if (toMemWriteEnable || dataMemRead) begin
                    state_d = D_ACC;
                    daddr_d = dataMemAddress;
                    wdata_d = dataOut;
                    we_d    = toMemWriteEnable;
                end else begin
                    state_d = I_ACC;
                end
            end
            D_ACC: begin
                if (acc_done) begin
                    // Stores leave the load-data register untouched.
                    if (!we_q) begin
                        din_d = fill_dat;
                    end
                    state_d = I_ACC;
                end
            end
            I_ACC: begin
                if (acc_done) begin
                    instr_d = fill_dat;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            daddr_q <= '0;
            iaddr_q <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            instr_q <= '0;
            din_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            daddr_q <= daddr_d;
            iaddr_q <= iaddr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            instr_q <= instr_d;
            din_q   <= din_d;
            err_q   <= err_d;
        end
    end

    // Memory-side outputs decode straight from the state register, so req drops the edge ack is taken.
    assign stall     = (state_q != DONE);
    assign mem_req   = in_access;
    assign mem_we    = (state_q == D_ACC) && we_q;
    assign mem_addr  = (state_q == D_ACC) ? daddr_q :
                       (state_q == I_ACC) ? iaddr_q : '0;
    assign mem_wdata = (state_q == D_ACC) ? wdata_q : '0;

    assign instruction = instr_q;
    assign dataIn      = din_q;
    assign err         = err_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Scoreboard bench for mem_bridge: a scripted req/ack memory, access and result queues, negedge monitor.
module tb_mem_bridge;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instructionAddress, dataMemAddress, dataOut;
    logic        toMemWriteEnable, dataMemRead;
    logic [31:0] instruction, dataIn;
    logic        stall;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_we, mem_req;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        err;

    always #5 clk = ~clk;

    mem_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .instructionAddress(instructionAddress), .dataMemAddress(dataMemAddress),
        .dataOut(dataOut), .toMemWriteEnable(toMemWriteEnable), .dataMemRead(dataMemRead),
        .instruction(instruction), .dataIn(dataIn), .stall(stall),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_req(mem_req),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } acc_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] din;
        logic        err;
        logic [31:0] lat;
    } res_t;

    acc_t exp_acc[$];
    res_t exp_res[$];
    int   checks = 0;
    int   errors = 0;

    // Scripted memory: entry k answers the k-th request after resp_w[k] wait cycles.
    int          resp_w[0:31];
    logic [31:0] resp_d[0:31];
    int          n_resp = 0;
    int          ptr = 0;
    int          wcnt = 0;
    logic        stray_ack = 1'b0;
    logic        m_hs, m_req;

    assign mem_ack   = (mem_req && (ptr < n_resp) && (wcnt >= resp_w[ptr])) || stray_ack;
    assign mem_rdata = stray_ack ? 32'hBAD0_BAD0 : resp_d[ptr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_resp(input int w, input logic [31:0] d);
        resp_w[n_resp] = w;
        resp_d[n_resp] = d;
        n_resp++;
    endtask

    task automatic exp_a(input logic [31:0] a, input logic we, input logic [31:0] wd);
        acc_t e;
        e.addr = a; e.we = we; e.wdata = wd;
        exp_acc.push_back(e);
    endtask

    task automatic exp_r(input logic [31:0] i, input logic [31:0] d, input logic e, input int lat);
        res_t r;
        r.instr = i; r.din = d; r.err = e; r.lat = lat;
        exp_res.push_back(r);
    endtask

    task automatic set_cpu(input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
                           input logic we, input logic rd);
        instructionAddress = ia;
        dataMemAddress     = da;
        dataOut            = wd;
        toMemWriteEnable   = we;
        dataMemRead        = rd;
    endtask

    task automatic wait_release();
        bit got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk);
            #1;
            if (!stall) got = 1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL release_timeout: stall=%b after 100 cycles, expected 0", stall);
        end
    endtask

    // Memory model: advance the script after each handshake or abandoned request.
    initial begin
        for (int i = 0; i < 32; i++) begin
            resp_w[i] = 0;
            resp_d[i] = 32'h0;
        end
        forever begin
            @(negedge clk);
            m_hs  = mem_req && mem_ack;
            m_req = mem_req;
            @(posedge clk);
            #1;
            if (m_hs || (m_req && !mem_req)) begin
                ptr++;
                wcnt = 0;
            end else if (m_req) begin
                wcnt++;
            end
        end
    end

    // Monitor: memory accesses, request stability and released results.
    int          cyc = 0;
    logic        pw = 1'b0;
    logic [31:0] pa;
    logic        pwe;
    initial begin
        acc_t a;
        res_t r;
        forever begin
            @(negedge clk);
            if (reset) begin
                cyc = 0;
            end else begin
                cyc++;
                if (mem_req && mem_ack) begin
                    if (exp_acc.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL acc_unexpected: access at %h, none expected", mem_addr);
                    end else begin
                        a = exp_acc.pop_front();
                        check("acc_addr", mem_addr, a.addr);
                        check("acc_we", {31'b0, mem_we}, {31'b0, a.we});
                        if (a.we) check("acc_wdata", mem_wdata, a.wdata);
                    end
                end
                if (pw && mem_req) begin
                    check("hold_addr", mem_addr, pa);
                    check("hold_we", {31'b0, mem_we}, {31'b0, pwe});
                end
                if (!stall) begin
                    if (exp_res.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL res_unexpected: release with instruction %h", instruction);
                    end else begin
                        r = exp_res.pop_front();
                        check("res_instruction", instruction, r.instr);
                        check("res_dataIn", dataIn, r.din);
                        check("res_err", {31'b0, err}, {31'b0, r.err});
                        check("res_latency", cyc, r.lat);
                    end
                    cyc = 0;
                end
            end
            pw  = mem_req && !mem_ack && !reset;
            pa  = mem_addr;
            pwe = mem_we;
        end
    end

    initial begin
        reset = 1'b1;
        set_cpu(32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", {31'b0, stall}, 32'h1);
        check("rst_mem_req", {31'b0, mem_req}, 32'h0);
        check("rst_mem_we", {31'b0, mem_we}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_instruction", instruction, 32'h0);
        check("rst_dataIn", dataIn, 32'h0);
        check("rst_err", {31'b0, err}, 32'h0);

        // Fetch only, zero-wait memory.
        add_resp(0, 32'h2008_0005);
        exp_a(32'h0, 1'b0, 32'h0);
        exp_r(32'h2008_0005, 32'h0, 1'b0, 3);
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_release();

        // Load then fetch.
        set_cpu(32'h4, 32'h100, 32'h0, 1'b0, 1'b1);
        add_resp(0, 32'hCAFE_0001);
        add_resp(0, 32'h0000_0020);
        exp_a(32'h100, 1'b0, 32'h0);
        exp_a(32'h4, 1'b0, 32'h0);
        exp_r(32'h20, 32'hCAFE_0001, 1'b0, 4);
        wait_release();

        // Store keeps the previous load data.
        set_cpu(32'h8, 32'h200, 32'h1234_5678, 1'b1, 1'b0);
        add_resp(0, 32'hDEAD_BEEF);
        add_resp(0, 32'h33);
        exp_a(32'h200, 1'b1, 32'h1234_5678);
        exp_a(32'h8, 1'b0, 32'h0);
        exp_r(32'h33, 32'hCAFE_0001, 1'b0, 4);
        wait_release();

        // Store and load together behave as a store.
        set_cpu(32'hC, 32'h300, 32'hA5A5_A5A5, 1'b1, 1'b1);
        add_resp(0, 32'h1111);
        add_resp(0, 32'h44);
        exp_a(32'h300, 1'b1, 32'hA5A5_A5A5);
        exp_a(32'hC, 1'b0, 32'h0);
        exp_r(32'h44, 32'hCAFE_0001, 1'b0, 4);
        wait_release();

        // Three wait cycles per access: release on cycle 10.
        set_cpu(32'h10, 32'h400, 32'h0, 1'b0, 1'b1);
        add_resp(3, 32'hBEEF_0002);
        add_resp(3, 32'h55);
        exp_a(32'h400, 1'b0, 32'h0);
        exp_a(32'h10, 1'b0, 32'h0);
        exp_r(32'h55, 32'hBEEF_0002, 1'b0, 10);
        wait_release();

        // CPU inputs change while stalled; the fetch in flight is unaffected.
        set_cpu(32'h14, 32'h0, 32'h0, 1'b0, 1'b0);
        add_resp(2, 32'h66);
        exp_a(32'h14, 1'b0, 32'h0);
        exp_r(32'h66, 32'hBEEF_0002, 1'b0, 5);
        repeat (2) @(posedge clk);
        #1;
        set_cpu(32'h999, 32'h600, 32'hFFFF, 1'b1, 1'b1);
        wait_release();

        // Reset in the middle of a slow load; a stray ack in IDLE is ignored.
        set_cpu(32'h18, 32'h500, 32'h0, 1'b0, 1'b1);
        add_resp(100, 32'h0001_2345);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        set_cpu(32'h1C, 32'h0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("midrst_mem_req", {31'b0, mem_req}, 32'h0);
        check("midrst_stall", {31'b0, stall}, 32'h1);
        check("midrst_instruction", instruction, 32'h0);
        check("midrst_dataIn", dataIn, 32'h0);
        reset = 1'b0;
        stray_ack = 1'b1;
        add_resp(0, 32'h77);
        exp_a(32'h1C, 1'b0, 32'h0);
        exp_r(32'h77, 32'h0, 1'b0, 3);
        @(posedge clk);
        #1;
        stray_ack = 1'b0;
        wait_release();

`ifdef MEM_BRIDGE_TIMEOUT_EN
        // Fetch never acked: forced completion after TO wait cycles, err sticks.
        set_cpu(32'h20, 32'h0, 32'h0, 1'b0, 1'b0);
        add_resp(1000, 32'h0);
        exp_r(32'hFFFF_FFFF, 32'h0, 1'b1, 2 + TO);
        wait_release();
        set_cpu(32'h24, 32'h0, 32'h0, 1'b0, 1'b0);
        add_resp(0, 32'h88);
        exp_a(32'h24, 1'b0, 32'h0);
        exp_r(32'h88, 32'h0, 1'b1, 3);
        wait_release();
`endif

        // Final fetch hangs on a silent memory until reset clears everything.
        set_cpu(32'h28, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("end_err", {31'b0, err}, 32'h0);
        check("end_stall", {31'b0, stall}, 32'h1);
        check("end_mem_req", {31'b0, mem_req}, 32'h0);
        check("end_instruction", instruction, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("res_queue_left", exp_res.size(), 32'h0);
        check("acc_queue_left", exp_acc.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bridge.md
Name: mem_bridge

Overview:
- Sits directly downstream of the pipelined CPU's memory ports. Converts the CPU's separate instruction-fetch port and data port into accesses on one shared single-port memory that has variable latency and uses a request/acknowledge handshake.
- Serialises the two accesses each CPU cycle, data first, then instruction.
- Returns registered results to the CPU and drives a stall output that freezes the pipeline until both accesses are complete.

Parameters:
- ADDR_WIDTH, 32, width of all address buses.
- DATA_WIDTH, 32, width of all data buses.
- TIMEOUT_CYCLES, 16, maximum number of wait cycles per access. Used only when the optional feature is compiled in.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- instructionAddress  in  ADDR_WIDTH  fetch address from the CPU's PC.
- dataMemAddress  in  ADDR_WIDTH  load/store address from the CPU.
- dataOut  in  DATA_WIDTH  store data from the CPU.
- toMemWriteEnable  in  1  CPU store request.
- dataMemRead  in  1  CPU load request.
- instruction  out  DATA_WIDTH  registered fetched instruction.
- dataIn  out  DATA_WIDTH  registered load data.
- stall  out  1  high means the CPU must hold all pipeline registers.
- mem_addr  out  ADDR_WIDTH  address to the shared memory.
- mem_wdata  out  DATA_WIDTH  write data to the shared memory.
- mem_we  out  1  write enable, qualified by mem_req.
- mem_req  out  1  access request, held high until ack.
- mem_rdata  in  DATA_WIDTH  memory read data, valid in the cycle mem_ack is high.
- mem_ack  in  1  one-cycle completion pulse from the memory.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset:
  - state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - instruction=0, dataIn=0, err=0, stall=1.
- FSM states and transitions:
  - IDLE: samples the CPU inputs.
    - toMemWriteEnable|dataMemRead -> D_ACC, with data address, write data and we latched.
    - otherwise -> I_ACC, with instructionAddress latched.
  - D_ACC: mem_req=1, mem_addr=latched data address, mem_we=latched write enable, mem_wdata=latched store data.
    - On mem_ack: if it is a read, dataIn<=mem_rdata; if it is a write, dataIn is unchanged. Then -> I_ACC.
  - I_ACC: mem_req=1, mem_we=0, mem_addr=latched instructionAddress.
    - On mem_ack: instruction<=mem_rdata, then -> DONE.
  - DONE: stall=0 for exactly one cycle, during which the CPU advances. -> IDLE.
- stall=1 in every state except DONE. This is a Moore output, registered from state.
- If toMemWriteEnable and dataMemRead are both high, the access is a write; dataIn is unchanged.
- Latency with zero-wait memory (ack in the first cycle of req):
  - Fetch only: 3 cycles (IDLE, I_ACC, DONE).
  - Data plus fetch: 4 cycles.
  - Each extra wait cycle adds 1.
- mem_ack is ignored in IDLE and DONE. An ack arriving in the same cycle req rises completes that access.
- mem_req drops in the cycle after ack is sampled. There are never back-to-back requests without a state change.
- CPU inputs are sampled only in IDLE. Changes during stall have no effect.
- reset asserted in any state forces IDLE on the next edge. An in-flight mem_req drops immediately at that edge, and the memory must tolerate an abandoned request.
- Addresses pass through unmodified, with no alignment checks.

Optional Feature:
- Macro MEM_BRIDGE_TIMEOUT_EN.
- With the macro defined:
  - A wait counter clears on entry to D_ACC or I_ACC and increments on each cycle in that state without mem_ack.
  - When the count reaches TIMEOUT_CYCLES, the access completes as if acked: its destination register (instruction, or dataIn on a read) takes 32'hFFFF_FFFF, err<=1 (sticky until reset), and the FSM proceeds normally.
- Without the macro: no counter, the FSM waits indefinitely for mem_ack, and err is tied to 0.

Test Plan:
- Reset, then instructionAddress=0x0, no data request, memory acks immediately with 0x2008_0005 -> stall high for 2 cycles then low for 1; instruction=0x2008_0005; mem_we never high.
- Load: dataMemRead=1, dataMemAddress=0x100, instructionAddress=0x4; memory returns 0xCAFE_0001 then 0x0000_0020 -> first mem_addr=0x100, then mem_addr=0x4; dataIn=0xCAFE_0001, instruction=0x20; 4 stall-then-release cycles.
- Store: toMemWriteEnable=1, dataMemAddress=0x200, dataOut=0x1234_5678 -> mem_we=1 with mem_addr=0x200, mem_wdata=0x1234_5678; dataIn keeps its previous value; fetch follows with mem_we=0.
- Memory with 3 wait cycles on each access: mem_req held steady, and mem_addr stable until ack -> release on cycle 10 after IDLE (data+fetch), results correct.
- Assert reset mid-D_ACC -> next edge mem_req=0, stall=1, instruction=0, dataIn=0; the late ack is ignored.
- With MEM_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=4, memory never acks the fetch -> after 4 wait cycles instruction=0xFFFF_FFFF, err=1, stall released; err stays 1 until reset.
